// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multi-cycle control sequencer for the 16-bit, 4-register MIPS
//                datapath. It stalls on the memory ready handshake and halts on
//                an undefined opcode or a memory timeout. When the macro
//                MC_CONTROL_INSTR_COUNT_EN is defined, the block also has a
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
`ifdef MC_CONTROL_INSTR_COUNT_EN
    output logic [CNT_W-1:0] retired,
`endif
    output logic [3:0]       state,
    output logic             halted,
    output logic             pc_we,
    output logic             pc_src,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctl
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_RWB    = 4'd4,
        S_IEXEC  = 4'd5,
        S_IWB    = 4'd6,
        S_MEMADR = 4'd7,
        S_MEMRD  = 4'd8,
        S_MEMWB  = 4'd9,
        S_MEMWR  = 4'd10,
        S_BRANCH = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic       halted;
        logic       pc_src;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
    } ctl_t;

    localparam int              WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;

    state_t              r_state;
    state_t              w_next;
    ctl_t                r_ctl;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_wait_st;
    logic                w_timeout;
    logic                w_br_take;
    logic                w_fetch_done;

    function automatic logic [3:0] f_alu(input logic [3:0] op);
        logic [3:0] v;
        case (op)
            4'd0:    v = 4'b0010;
            4'd1:    v = 4'b0110;
            4'd2:    v = 4'b0000;
            4'd3:    v = 4'b0001;
            4'd4:    v = 4'b1100;
            4'd5:    v = 4'b1101;
            4'd6:    v = 4'b0111;
            default: v = 4'b0010;
        endcase
        return v;
    endfunction

    // Control word for the state being entered; opcode is stable from DECODE on.
    function automatic ctl_t f_ctl(input state_t s, input logic [3:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctl   = c_ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctl   = c_ALU_ADD;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = f_alu(op);
            end
            S_RWB: begin
                c.reg_we  = 1'b1;
                c.reg_dst = 1'b1;
            end
            S_IEXEC, S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctl   = c_ALU_ADD;
            end
            S_IWB: c.reg_we = 1'b1;
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_we     = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = c_ALU_SUB;
                c.pc_src    = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        // A ready in the last allowed cycle still wins over the timeout.
        w_timeout = (TIMEOUT != 0) && w_wait_st && !mem_ready && (r_wait == c_WAIT_LAST);
        w_br_take = ((opcode == 4'b1010) && zero) || ((opcode == 4'b1011) && !zero);
        w_next    = r_state;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: begin
                if (opcode <= 4'd6)       w_next = S_EXEC;
                else if (opcode == 4'd7)  w_next = S_IEXEC;
                else if (opcode <= 4'd9)  w_next = S_MEMADR;
                else if (opcode <= 4'd11) w_next = S_BRANCH;
                else                      w_next = S_HALT;
            end
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_MEMADR: w_next = (opcode == 4'b1000) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_HALT;
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_BRANCH: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_HALT;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
            r_ctl   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctl(w_next, opcode);
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_wait_st && !mem_ready && (TIMEOUT != 0))
                r_wait <= r_wait + 1'b1;
        end
    end

`ifdef MC_CONTROL_INSTR_COUNT_EN
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    always_comb begin
        w_retire = (w_next == S_FETCH) &&
                   ((r_state == S_RWB) || (r_state == S_IWB) || (r_state == S_MEMWB) ||
                    (r_state == S_MEMWR) || (r_state == S_BRANCH));
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + 1'b1;
    end

    assign retired = r_retired;
`endif

    // Handshake- and flag-qualified enables must follow the inputs within the cycle.
    assign w_fetch_done = (r_state == S_FETCH) && mem_ready;

    assign state      = r_state;
    assign halted     = r_ctl.halted;
    assign ir_we      = w_fetch_done;
    assign pc_we      = w_fetch_done || ((r_state == S_BRANCH) && w_br_take);
    assign pc_src     = r_ctl.pc_src;
    assign iord       = r_ctl.iord;
    assign mem_req    = r_ctl.mem_req;
    assign mem_we     = r_ctl.mem_we;
    assign reg_dst    = r_ctl.reg_dst;
    assign mem_to_reg = r_ctl.mem_to_reg;
    assign reg_we     = r_ctl.reg_we;
    assign alu_src_a  = r_ctl.alu_src_a;
    assign alu_src_b  = r_ctl.alu_src_b;
    assign alu_ctl    = r_ctl.alu_ctl;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Self-checking bench for mc_control_fsm (TIMEOUT 15, 4 and 0),
//                directed vector table plus randomized model comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    localparam int N = 3;

    localparam logic [16:0] O_ZERO     = 17'b0;
    localparam logic [16:0] O_FETCH_R  = 17'b0_1_0_0_1_0_1_0_0_0_0_01_0010;
    localparam logic [16:0] O_FETCH_W  = 17'b0_0_0_0_1_0_0_0_0_0_0_01_0010;
    localparam logic [16:0] O_DEC      = 17'b0_0_0_0_0_0_0_0_0_0_0_11_0010;
    localparam logic [16:0] O_EXEC_ADD = 17'b0_0_0_0_0_0_0_0_0_0_1_00_0010;
    localparam logic [16:0] O_EXEC_SUB = 17'b0_0_0_0_0_0_0_0_0_0_1_00_0110;
    localparam logic [16:0] O_RWB      = 17'b0_0_0_0_0_0_0_1_0_1_0_00_0000;
    localparam logic [16:0] O_ADR      = 17'b0_0_0_0_0_0_0_0_0_0_1_10_0010;
    localparam logic [16:0] O_MRD      = 17'b0_0_0_1_1_0_0_0_0_0_0_00_0000;
    localparam logic [16:0] O_MWB      = 17'b0_0_0_0_0_0_0_0_1_1_0_00_0000;
    localparam logic [16:0] O_MWR      = 17'b0_0_0_1_1_1_0_0_0_0_0_00_0000;
    localparam logic [16:0] O_IWB      = 17'b0_0_0_0_0_0_0_0_0_1_0_00_0000;
    localparam logic [16:0] O_BR_T     = 17'b0_1_1_0_0_0_0_0_0_0_1_00_0110;
    localparam logic [16:0] O_BR_N     = 17'b0_0_1_0_0_0_0_0_0_0_1_00_0110;
    localparam logic [16:0] O_HALT     = 17'b1_0_0_0_0_0_0_0_0_0_0_00_0000;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic [3:0]  st_v  [N];
    logic [16:0] ob_v  [N];
    logic [15:0] ret_v [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    function automatic int tmo_of(input int i);
        return (i == 0) ? 15 : ((i == 1) ? 4 : 0);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        logic [3:0]  st;
        logic        halted, pc_we, pc_src, iord, mem_req, mem_we, ir_we;
        logic        reg_dst, mem_to_reg, reg_we, alu_src_a;
        logic [1:0]  alu_src_b;
        logic [3:0]  alu_ctl;
        logic [15:0] ret;

        mc_control_fsm #(
            .TIMEOUT ((gi == 0) ? 15 : ((gi == 1) ? 4 : 0)),
            .CNT_W   (16)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .opcode     (opcode),
            .zero       (zero),
            .mem_ready  (mem_ready),
`ifdef MC_CONTROL_INSTR_COUNT_EN
            .retired    (ret),
`endif
            .state      (st),
            .halted     (halted),
            .pc_we      (pc_we),
            .pc_src     (pc_src),
            .iord       (iord),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .ir_we      (ir_we),
            .reg_dst    (reg_dst),
            .mem_to_reg (mem_to_reg),
            .reg_we     (reg_we),
            .alu_src_a  (alu_src_a),
            .alu_src_b  (alu_src_b),
            .alu_ctl    (alu_ctl)
        );
`ifndef MC_CONTROL_INSTR_COUNT_EN
        assign ret = '0;
`endif
        assign st_v[gi]  = st;
        assign ob_v[gi]  = {halted, pc_we, pc_src, iord, mem_req, mem_we, ir_we,
                            reg_dst, mem_to_reg, reg_we, alu_src_a, alu_src_b, alu_ctl};
        assign ret_v[gi] = ret;
    end

    // ---------------- behavioural reference model ----------------
    int         m_st   [N];
    int         m_wait [N];
    int         m_ret  [N];
    logic [3:0] alu_tab [7];

    function automatic logic [16:0] exp_outs(input int s, input logic [3:0] op,
                                             input logic z, input logic rdy);
        logic h, pw, ps, io, mr, mw, iw, rd, m2r, rw, sa;
        logic [1:0] sb;
        logic [3:0] ac;
        {h, pw, ps, io, mr, mw, iw, rd, m2r, rw, sa} = '0;
        sb = 2'b00;
        ac = 4'b0000;
        case (s)
            1:  begin mr = 1; sb = 2'b01; ac = 4'b0010; iw = rdy; pw = rdy; end
            2:  begin sb = 2'b11; ac = 4'b0010; end
            3:  begin sa = 1; ac = (op <= 6) ? alu_tab[op] : 4'b0010; end
            4:  begin rw = 1; rd = 1; end
            5,
            7:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
            6:  rw = 1;
            8:  begin mr = 1; io = 1; end
            9:  begin rw = 1; m2r = 1; end
            10: begin mr = 1; mw = 1; io = 1; end
            11: begin sa = 1; ac = 4'b0110; ps = 1; pw = ((op == 10) && z) || ((op == 11) && !z); end
            15: h = 1;
            default: ;
        endcase
        return {h, pw, ps, io, mr, mw, iw, rd, m2r, rw, sa, sb, ac};
    endfunction

    task automatic model_adv(input int i, input logic [3:0] op, input logic rdy);
        int nx;
        case (m_st[i])
            0:  nx = 1;
            1:  nx = rdy ? 2 : 1;
            2:  nx = (op <= 6) ? 3 : (op == 7) ? 5 : (op <= 9) ? 7 : (op <= 11) ? 11 : 15;
            3:  nx = 4;
            5:  nx = 6;
            7:  nx = (op == 8) ? 8 : 10;
            8:  nx = rdy ? 9 : 8;
            10: nx = rdy ? 1 : 10;
            4, 6, 9, 11: nx = 1;
            default: nx = 15;
        endcase
        if ((m_st[i] == 1 || m_st[i] == 8 || m_st[i] == 10) && !rdy) begin
            m_wait[i]++;
            if (tmo_of(i) != 0 && m_wait[i] >= tmo_of(i)) nx = 15;
        end
        if (nx == 1 && (m_st[i] == 4 || m_st[i] == 6 || m_st[i] == 9 || m_st[i] == 10 || m_st[i] == 11))
            m_ret[i] = (m_ret[i] + 1) % 65536;
        if (nx != m_st[i]) m_wait[i] = 0;
        m_st[i] = nx;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered and left at posedge+1; holds reset across one active edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_state[%0d]", i), 32'(st_v[i]), 32'd0);
            chk($sformatf("reset_outs[%0d]", i), 32'(ob_v[i]), 32'(O_ZERO));
            m_st[i] = 0; m_wait[i] = 0; m_ret[i] = 0;
        end
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] outs;
    } vec_t;

    vec_t tbl [39];

    task automatic set_vec(input int k, input logic [3:0] op, input logic z, input logic rdy,
                           input logic [3:0] st, input logic [16:0] outs);
        tbl[k].op = op; tbl[k].z = z; tbl[k].rdy = rdy; tbl[k].st = st; tbl[k].outs = outs;
    endtask

    initial begin
        alu_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1101, 4'b0111};

        // ADD, stalled fetch, LW with 3 wait cycles, BEQ/BNE, SW, ADDI, SUB, undefined
        set_vec( 0,  0, 0, 1,  0, O_ZERO);     set_vec( 1,  0, 0, 1,  1, O_FETCH_R);
        set_vec( 2,  0, 0, 1,  2, O_DEC);      set_vec( 3,  0, 0, 1,  3, O_EXEC_ADD);
        set_vec( 4,  0, 0, 1,  4, O_RWB);      set_vec( 5,  0, 0, 0,  1, O_FETCH_W);
        set_vec( 6,  8, 0, 1,  1, O_FETCH_R);  set_vec( 7,  8, 0, 1,  2, O_DEC);
        set_vec( 8,  8, 0, 1,  7, O_ADR);      set_vec( 9,  8, 0, 0,  8, O_MRD);
        set_vec(10,  8, 0, 0,  8, O_MRD);      set_vec(11,  8, 0, 0,  8, O_MRD);
        set_vec(12,  8, 0, 1,  8, O_MRD);      set_vec(13,  8, 0, 1,  9, O_MWB);
        set_vec(14, 10, 1, 1,  1, O_FETCH_R);  set_vec(15, 10, 1, 1,  2, O_DEC);
        set_vec(16, 10, 1, 1, 11, O_BR_T);     set_vec(17, 11, 1, 1,  1, O_FETCH_R);
        set_vec(18, 11, 1, 1,  2, O_DEC);      set_vec(19, 11, 1, 1, 11, O_BR_N);
        set_vec(20, 11, 0, 1,  1, O_FETCH_R);  set_vec(21, 11, 0, 1,  2, O_DEC);
        set_vec(22, 11, 0, 1, 11, O_BR_T);     set_vec(23,  9, 0, 1,  1, O_FETCH_R);
        set_vec(24,  9, 0, 1,  2, O_DEC);      set_vec(25,  9, 0, 1,  7, O_ADR);
        set_vec(26,  9, 0, 0, 10, O_MWR);      set_vec(27,  9, 0, 1, 10, O_MWR);
        set_vec(28,  7, 0, 1,  1, O_FETCH_R);  set_vec(29,  7, 0, 1,  2, O_DEC);
        set_vec(30,  7, 0, 1,  5, O_ADR);      set_vec(31,  7, 0, 1,  6, O_IWB);
        set_vec(32,  1, 0, 1,  1, O_FETCH_R);  set_vec(33,  1, 0, 1,  2, O_DEC);
        set_vec(34,  1, 0, 1,  3, O_EXEC_SUB); set_vec(35,  1, 0, 1,  4, O_RWB);
        set_vec(36, 12, 0, 1,  1, O_FETCH_R);  set_vec(37, 12, 0, 1,  2, O_DEC);
        set_vec(38, 12, 0, 1, 15, O_HALT);

        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        do_reset();

        for (int k = 0; k < 39; k++) begin
            opcode = tbl[k].op; zero = tbl[k].z; mem_ready = tbl[k].rdy;
            #2;
            chk($sformatf("vec%0d_state", k), 32'(st_v[0]), 32'(tbl[k].st));
            chk($sformatf("vec%0d_outs", k), 32'(ob_v[0]), 32'(tbl[k].outs));
            tick();
        end
`ifdef MC_CONTROL_INSTR_COUNT_EN
        chk("retired_after_table", 32'(ret_v[0]), 32'd8);
`endif

        // HALT absorbs whatever the memory does
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            opcode    = 4'($urandom_range(0, 15));
            #2;
            chk($sformatf("halt%0d_state", k), 32'(st_v[0]), 32'd15);
            chk($sformatf("halt%0d_outs", k), 32'(ob_v[0]), 32'(O_HALT));
            tick();
        end
`ifdef MC_CONTROL_INSTR_COUNT_EN
        chk("retired_frozen", 32'(ret_v[0]), 32'd8);
`endif
        do_reset();

        // Fetch starved of mem_ready: per-instance timeout
        mem_ready = 1'b0;
        #2;
        chk("tmo_rst_state", 32'(st_v[0]), 32'd0);
        tick();
        for (int k = 0; k < 30; k++) begin
            #2;
            for (int i = 0; i < N; i++)
                chk($sformatf("tmo%0d_state[%0d]", k, i), 32'(st_v[i]),
                    (tmo_of(i) != 0 && k >= tmo_of(i)) ? 32'd15 : 32'd1);
            tick();
        end
        do_reset();

        // Asynchronous reset in the middle of a stalled store
        mem_ready = 1'b1; tick();
        tick();
        opcode = 4'd9; tick();
        tick();
        mem_ready = 1'b0;
        #2;
        chk("mwr_state", 32'(st_v[0]), 32'd10);
        chk("mwr_outs", 32'(ob_v[0]), 32'(O_MWR));
        tick();
        chk("mwr_hold_state", 32'(st_v[0]), 32'd10);
        reset = 1'b1;
        #1;
        chk("async_state", 32'(st_v[0]), 32'd0);
        chk("async_mem_ctl", 32'(ob_v[0][13:11]), 32'd0);
        tick();
        do_reset();

        // Randomized episodes against the model
        for (int ep = 0; ep < 25; ep++) begin
            int thr;
            thr = $urandom_range(1, 4);
            for (int c = 0; c < 60; c++) begin
                bit idle;
                idle = 1'b1;
                for (int i = 0; i < N; i++)
                    if (!(m_st[i] == 0 || m_st[i] == 1 || m_st[i] == 15)) idle = 1'b0;
                if (idle)
                    opcode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                        : 4'($urandom_range(0, 11));
                zero      = 1'($urandom_range(0, 1));
                mem_ready = ($urandom_range(0, 4) < thr);
                #2;
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("rnd%0d_%0d_state[%0d]", ep, c, i), 32'(st_v[i]), 32'(m_st[i]));
                    chk($sformatf("rnd%0d_%0d_outs[%0d]", ep, c, i), 32'(ob_v[i]),
                        32'(exp_outs(m_st[i], opcode, zero, mem_ready)));
`ifdef MC_CONTROL_INSTR_COUNT_EN
                    chk($sformatf("rnd%0d_%0d_ret[%0d]", ep, c, i), 32'(ret_v[i]), 32'(m_ret[i]));
`endif
                    model_adv(i, opcode, mem_ready);
                end
                tick();
            end
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
